fu_cdb_writer: RTL and testbench
================================

FU_CDB_WRITER -- requirements
Module: fu_cdb_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  all state updates on posedge; the issuing station drives on negedge.
REQ-003 rst  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 RS_FU_RS_ID  input  5  station entry ID; nonzero means an issue is valid this cycle.
REQ-005 RS_FU_ROBEN  input  5  destination ROB entry; 0 is never a valid tag.
REQ-006 RS_FU_opcode  input  12  {op[5:0],funct[5:0]}; op != 0 selects Immediate as operand B, else Val2.
REQ-007 RS_FU_ALUOP  input  4  operation select.
REQ-008 RS_FU_Val1, RS_FU_Val2, RS_FU_Immediate  input  32 each  operand A, register operand B, immediate.
REQ-009 ROB_FLUSH_Flag  input  1  squash everything in flight.
REQ-010 CDB_Grant  input  1  arbiter accepts the current CDB head this cycle.
REQ-011 FU_Is_Free  output  1  block can accept an issue at the next posedge.
REQ-012 CDB_ROBEN  output  5  head result tag; 0 means no result pending.
REQ-013 CDB_VAL  output  32  head result value; 0 when CDB_ROBEN is 0.

Function
REQ-014 ALUOP encoding SHALL be as follows; codes 12-15 yield result 0, single-cycle:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
- 6 SLL, 7 SRL, 8 SRA, with shift amount B[4:0]
- 9 SLT (signed), 10 SLTU, 11 MUL (low 32 bits of A*B)
REQ-015 All arithmetic SHALL be 32-bit modulo with no overflow trap; SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-016 An issue SHALL be accepted at a posedge when RS_FU_RS_ID != 0, FU_Is_Free = 1, ROB_FLUSH_Flag = 0 and rst = 0; otherwise it SHALL be ignored with no state change.
REQ-017 The FSM SHALL have states IDLE and MUL_BUSY; reset state is IDLE.
REQ-018 Single-cycle op accepted at posedge N: the result SHALL be pushed into the output FIFO at posedge N, and the state SHALL remain IDLE.
REQ-019 MUL accepted at posedge N: the block SHALL go IDLE->MUL_BUSY, latch operands, ROBEN and a cycle counter of 3, then decrement each posedge; at posedge N+3 it SHALL push the result and return to IDLE.
REQ-020 The output FIFO SHALL have 2 entries of {ROBEN, value}, use a 2-bit count 0..2, and be in-order.
REQ-021 CDB_ROBEN/CDB_VAL SHALL be driven combinationally from the FIFO head.
REQ-022 The head SHALL be popped at a posedge when CDB_Grant = 1 and count > 0; CDB_Grant with an empty FIFO SHALL be ignored.
REQ-023 Simultaneous push and pop SHALL leave the count unchanged, with data order preserved; at count 2, a pop plus a MUL completion push SHALL be legal.
REQ-024 FU_Is_Free SHALL equal (state == IDLE) && (count + pending MUL completion < 2), derived from registered state only.
REQ-025 A pushed result SHALL never overwrite an unpopped entry; REQ-024 guarantees this, and a violation is a design error flagged by assertion.
REQ-026 ROB_FLUSH_Flag at a posedge SHALL empty the FIFO, abort any MUL (state to IDLE, counter 0) and drop any same-cycle issue; a same-cycle CDB_Grant has no further effect.

Reset
REQ-027 On rst the block SHALL set state IDLE, counter 0, FIFO count and pointers 0, CDB_ROBEN = 0, CDB_VAL = 0 and FU_Is_Free = 1, effective asynchronously.
REQ-028 Reset asserted mid-MUL or with a full FIFO SHALL discard all pending results; after deassertion no stale tag SHALL appear on the CDB.

Verification
REQ-029 ADD issue: Val1 = 5, Val2 = 7, ROBEN = 3, opcode op = 0, Grant = 0 -> after the posedge CDB_ROBEN = 3, CDB_VAL = 12, held until Grant, then 0.
REQ-030 SUB with immediate: op = 8, Val1 = 2, Immediate = 5 -> CDB_VAL = 32'hFFFFFFFD; SRA on 32'h80000000 by 4 -> 32'hF8000000; SLTU of 1 vs 32'hFFFFFFFF -> 1.
REQ-031 MUL 32'h10000 * 32'h10001, ROBEN = 9 -> FU_Is_Free = 0 for 3 cycles, then CDB_ROBEN = 9, CDB_VAL = 32'h00010000.
REQ-032 Two ADDs (ROBEN 1, 2) with Grant = 0 -> FU_Is_Free = 0 at count 2; a third issue is ignored; Grant pops 1 then 2 in order, and FU_Is_Free returns to 1.
REQ-033 Flush during MUL with one result queued -> next cycle CDB_ROBEN = 0 and FU_Is_Free = 1, and no MUL result ever appears.
REQ-034 rst pulse between posedges with a full FIFO -> CDB_ROBEN = 0 immediately; a post-reset ADD behaves as in REQ-029.

Source files
------------

// File: rtl/fu_cdb_writer.sv
// Integer functional unit: single-cycle ALU results queue on the posedge of issue, MUL completes 3 posedges later.
// Results wait in a 2-entry in-order FIFO for CDB_Grant; FU_Is_Free drops when a new result could not be queued.
module fu_cdb_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RS_FU_RS_ID,
    input  logic [4:0]  RS_FU_ROBEN,
    input  logic [11:0] RS_FU_opcode,
    input  logic [3:0]  RS_FU_ALUOP,
    input  logic [31:0] RS_FU_Val1,
    input  logic [31:0] RS_FU_Val2,
    input  logic [31:0] RS_FU_Immediate,
    input  logic        ROB_FLUSH_Flag,
    input  logic        CDB_Grant,
    output logic        FU_Is_Free,
    output logic [4:0]  CDB_ROBEN,
    output logic [31:0] CDB_VAL
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef struct packed {
        logic [4:0]  rob;
        logic [31:0] val;
    } cdb_ent_t;

    logic [0:0]  state_q, state_d;
    logic [1:0]  mul_cnt_q, mul_cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [4:0]  mul_rob_q, mul_rob_d;
    cdb_ent_t    fifo_q [2];
    cdb_ent_t    fifo_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [31:0] alu_res;
    logic [31:0] mul_res;
    logic        issue_ok;
    logic        is_mul;
    logic        mul_done;
    logic        push;
    logic        pop;
    cdb_ent_t    push_dat;
    cdb_ent_t    head;
    logic [2:0]  occupancy;
    logic        unused_funct;

    assign unused_funct = ^RS_FU_opcode[5:0];

    assign opnd_a = RS_FU_Val1;
    assign opnd_b = (RS_FU_opcode[11:6] != 6'd0) ? RS_FU_Immediate : RS_FU_Val2;

    always_comb begin
        alu_res = 32'd0;
        case (RS_FU_ALUOP)
            OP_ADD:  alu_res = opnd_a + opnd_b;
            OP_SUB:  alu_res = opnd_a - opnd_b;
            OP_AND:  alu_res = opnd_a & opnd_b;
            OP_OR:   alu_res = opnd_a | opnd_b;
            OP_XOR:  alu_res = opnd_a ^ opnd_b;
            OP_NOR:  alu_res = ~(opnd_a | opnd_b);
            OP_SLL:  alu_res = opnd_a << opnd_b[4:0];
            OP_SRL:  alu_res = opnd_a >> opnd_b[4:0];
            OP_SRA:  alu_res = $signed(opnd_a) >>> opnd_b[4:0];
            OP_SLT:  alu_res = {31'd0, $signed(opnd_a) < $signed(opnd_b)};
            OP_SLTU: alu_res = {31'd0, opnd_a < opnd_b};
            default: alu_res = 32'd0;
        endcase
    end

    assign mul_res = mul_a_q * mul_b_q;

    // Free only if a result produced now could be queued without overwriting.
    assign occupancy  = {1'b0, count_q} + {2'b00, mul_done};
    assign FU_Is_Free = (state_q == ST_IDLE) && (occupancy < 3'd2);

    assign is_mul   = (RS_FU_ALUOP == OP_MUL);
    assign issue_ok = (RS_FU_RS_ID != 5'd0) && FU_Is_Free && !ROB_FLUSH_Flag;
    assign mul_done = (state_q == ST_MUL_BUSY) && (mul_cnt_q == 2'd1);

    // Single-cycle issue needs IDLE and MUL completion needs MUL_BUSY, so at most one push source.
    always_comb begin
        push     = 1'b0;
        push_dat = '0;
        if (issue_ok && !is_mul) begin
            push     = 1'b1;
            push_dat = '{rob: RS_FU_ROBEN, val: alu_res};
        end else if (mul_done && !ROB_FLUSH_Flag) begin
            push     = 1'b1;
            push_dat = '{rob: mul_rob_q, val: mul_res};
        end
    end

    assign pop = CDB_Grant && (count_q != 2'd0) && !ROB_FLUSH_Flag;

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_rob_d = mul_rob_q;
        case (state_q)
            ST_IDLE: begin
                if (issue_ok && is_mul) begin
                    state_d   = ST_MUL_BUSY;
                    mul_cnt_d = 2'd3;
                    mul_a_d   = opnd_a;
                    mul_b_d   = opnd_b;
                    mul_rob_d = RS_FU_ROBEN;
                end
            end
            default: begin
                if (mul_cnt_q == 2'd1) begin
                    state_d   = ST_IDLE;
                    mul_cnt_d = 2'd0;
                end else begin
                    mul_cnt_d = mul_cnt_q - 2'd1;
                end
            end
        endcase
        if (ROB_FLUSH_Flag) begin
            state_d   = ST_IDLE;
            mul_cnt_d = 2'd0;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (ROB_FLUSH_Flag) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = push_dat;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mul_cnt_q <= 2'd0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            mul_rob_q <= 5'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_rob_q <= mul_rob_d;
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign CDB_ROBEN = (count_q != 2'd0) ? head.rob : 5'd0;
    assign CDB_VAL   = (count_q != 2'd0) ? head.val : 32'd0;

    a_no_overwrite : assert property (@(posedge clk) disable iff (rst)
        !(push && (count_q == 2'd2) && !pop));

endmodule

// File: tb/tb_fu_cdb_writer.sv
// Directed bench for fu_cdb_writer: hand-computed results checked on the CDB outputs.
module tb_fu_cdb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id;
    logic [4:0]  roben;
    logic [11:0] opcode;
    logic [3:0]  aluop;
    logic [31:0] val1, val2, imm;
    logic        flush;
    logic        grant;
    logic        fu_free;
    logic [4:0]  cdb_roben;
    logic [31:0] cdb_val;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fu_cdb_writer dut (
        .clk             (clk),
        .rst             (rst),
        .RS_FU_RS_ID     (rs_id),
        .RS_FU_ROBEN     (roben),
        .RS_FU_opcode    (opcode),
        .RS_FU_ALUOP     (aluop),
        .RS_FU_Val1      (val1),
        .RS_FU_Val2      (val2),
        .RS_FU_Immediate (imm),
        .ROB_FLUSH_Flag  (flush),
        .CDB_Grant       (grant),
        .FU_Is_Free      (fu_free),
        .CDB_ROBEN       (cdb_roben),
        .CDB_VAL         (cdb_val)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next posedge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rob, input logic [11:0] opc, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        rs_id  = 5'd1;
        roben  = rob;
        opcode = opc;
        aluop  = op;
        val1   = a;
        val2   = b;
        imm    = im;
    endtask

    task automatic idle_in();
        rs_id = 5'd0;
        roben = 5'd0;
    endtask

    // Issue one single-cycle op, check the head, then pop it.
    task automatic single(input string tag, input logic [4:0] rob, input logic [11:0] opc,
                          input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] exp);
        drive(rob, opc, op, a, b, im);
        step();
        idle_in();
        chk({tag, "_rob"}, {27'd0, cdb_roben}, {27'd0, rob});
        chk({tag, "_val"}, cdb_val, exp);
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk({tag, "_popped"}, {27'd0, cdb_roben}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; grant = 1'b0;
        idle_in(); opcode = '0; aluop = '0; val1 = '0; val2 = '0; imm = '0;
        #12;
        chk("rst_rob", {27'd0, cdb_roben}, 32'd0);
        chk("rst_val", cdb_val, 32'd0);
        chk("rst_free", {31'd0, fu_free}, 32'd1);
        step();
        rst = 1'b0;

        // ADD 5+7, held until granted
        drive(5'd3, 12'h000, 4'd0, 32'd5, 32'd7, 32'd99);
        step();
        idle_in();
        chk("add_rob", {27'd0, cdb_roben}, 32'd3);
        chk("add_val", cdb_val, 32'd12);
        chk("add_free", {31'd0, fu_free}, 32'd1);
        step();
        chk("add_hold", {27'd0, cdb_roben}, 32'd3);
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("add_pop_rob", {27'd0, cdb_roben}, 32'd0);
        chk("add_pop_val", cdb_val, 32'd0);

        single("subi", 5'd4, 12'h200, 4'd1, 32'd2, 32'd100, 32'd5, 32'hFFFF_FFFD);
        single("sra",  5'd5, 12'h000, 4'd8, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);
        single("sltu", 5'd6, 12'h000, 4'd10, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1);
        single("slt",  5'd7, 12'h000, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
        single("nor",  5'd8, 12'h000, 4'd5, 32'h0F0F_0000, 32'h0000_00F0, 32'd0, 32'hF0F0_FF0F);
        single("sll",  5'd10, 12'h000, 4'd6, 32'h0000_0003, 32'd36, 32'd0, 32'h0000_0030);
        single("op12", 5'd11, 12'h000, 4'd12, 32'd5, 32'd7, 32'd0, 32'd0);

        // Grant with an empty FIFO has no effect
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("empty_grant_free", {31'd0, fu_free}, 32'd1);
        chk("empty_grant_rob", {27'd0, cdb_roben}, 32'd0);

        // MUL: busy for three cycles, then result
        drive(5'd9, 12'h000, 4'd11, 32'h0001_0000, 32'h0001_0001, 32'd0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("mul_busy", {31'd0, fu_free}, 32'd0);
            chk("mul_noresult", {27'd0, cdb_roben}, 32'd0);
            if (i < 2) step();
        end
        step();
        chk("mul_free", {31'd0, fu_free}, 32'd1);
        chk("mul_rob", {27'd0, cdb_roben}, 32'd9);
        chk("mul_val", cdb_val, 32'h0001_0000);
        grant = 1'b1;
        step();
        grant = 1'b0;

        // Two queued results, third issue ignored, in-order drain
        drive(5'd1, 12'h000, 4'd0, 32'd1, 32'd1, 32'd0);
        step();
        chk("q1_free", {31'd0, fu_free}, 32'd1);
        drive(5'd2, 12'h000, 4'd0, 32'd2, 32'd2, 32'd0);
        step();
        chk("q2_free", {31'd0, fu_free}, 32'd0);
        drive(5'd13, 12'h000, 4'd0, 32'd3, 32'd3, 32'd0);
        step();
        idle_in();
        chk("q3_ignored", {27'd0, cdb_roben}, 32'd1);
        chk("q3_val", cdb_val, 32'd2);
        grant = 1'b1;
        step();
        chk("drain_2_rob", {27'd0, cdb_roben}, 32'd2);
        chk("drain_2_val", cdb_val, 32'd4);
        step();
        grant = 1'b0;
        chk("drain_empty", {27'd0, cdb_roben}, 32'd0);
        chk("drain_free", {31'd0, fu_free}, 32'd1);

        // Simultaneous push and pop at count 1
        drive(5'd14, 12'h000, 4'd2, 32'hFF00, 32'h0FF0, 32'd0);
        step();
        drive(5'd15, 12'h000, 4'd3, 32'hF000, 32'h000F, 32'd0);
        grant = 1'b1;
        step();
        grant = 1'b0;
        idle_in();
        chk("pp_rob", {27'd0, cdb_roben}, 32'd15);
        chk("pp_val", cdb_val, 32'h0000_F00F);
        chk("pp_free", {31'd0, fu_free}, 32'd1);

        // Flush during MUL with one result queued (rob 15 still queued)
        drive(5'd7, 12'h000, 4'd11, 32'd3, 32'd3, 32'd0);
        step();
        idle_in();
        chk("fl_busy", {31'd0, fu_free}, 32'd0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_rob", {27'd0, cdb_roben}, 32'd0);
        chk("fl_free", {31'd0, fu_free}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_mul", {27'd0, cdb_roben}, 32'd0);
        end

        // Async reset between posedges with a full FIFO
        drive(5'd10, 12'h000, 4'd0, 32'd1, 32'd0, 32'd0);
        step();
        drive(5'd11, 12'h000, 4'd0, 32'd2, 32'd0, 32'd0);
        step();
        idle_in();
        chk("full_free", {31'd0, fu_free}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rob", {27'd0, cdb_roben}, 32'd0);
        chk("arst_val", cdb_val, 32'd0);
        chk("arst_free", {31'd0, fu_free}, 32'd1);
        rst = 1'b0;
        step();
        chk("post_rst_stale", {27'd0, cdb_roben}, 32'd0);
        single("post_rst_add", 5'd3, 12'h000, 4'd0, 32'd5, 32'd7, 32'd0, 32'd12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
